// File: rtl/reg_bank_if.sv
// reg_bank_if: write-port and dual read-port bundle for reg_bank.
// Signals:
//   we   write enable
//   wa   write address
//   wd   write data
//   wbe  byte enables, bit i covers wd[8i+7:8i]
//   ra1  read address, port 1      rd1  read data, port 1
//   nrd1 bitwise complement of rd1
//   ra2  read address, port 2      rd2  read data, port 2
// Modports: master drives addresses/write data, slave (the bank) drives read data.
interface reg_bank_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [WIDTH/8-1:0] wbe;
    logic [AW-1:0]    ra1;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] nrd1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd2;
    modport master (output we, wa, wd, wbe, ra1, ra2, input rd1, nrd1, rd2);
    modport slave  (input we, wa, wd, wbe, ra1, ra2, output rd1, nrd1, rd2);
endinterface

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file, one byte-masked write port, two combinational read ports.
// Ports:
//   clk_i  rising-edge clock for all storage updates
//   rst_i  asynchronous active-high reset, clears every entry
//   bus    reg_bank_if.slave: we/wa/wd/wbe write port, ra1/rd1/nrd1 and ra2/rd2 read ports
// Parameters: WIDTH (multiple of 8), DEPTH (2..256), ZERO_R0 (entry 0 hardwired to zero),
//   BYPASS (same-cycle write forwarded to matching reads).
module reg_bank #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b0
) (
    input logic       clk_i,
    input logic       rst_i,
    reg_bank_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    // One extra bit so the range test is not trivially true when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] word_d;
    logic             wr_hit;
    logic             wr_en;

    // Address names a real, writable/readable entry (not out of range, not a hardwired zero).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !(ZERO_R0 && a == '0);
    endfunction

    // Merged word: the value entry wa holds after the edge; shared by the write and the bypass.
    always_comb begin
        word_d = mem_q[bus.wa];
        for (int b = 0; b < NB; b++)
            if (bus.wbe[b]) word_d[8*b +: 8] = bus.wd[8*b +: 8];
    end

    assign wr_hit = bus.we && !rst_i && addr_ok(bus.wa);
    assign wr_en  = wr_hit && |bus.wbe;

    function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
        return !addr_ok(a) ? '0 : (BYPASS && wr_hit && a == bus.wa) ? word_d : mem_q[a];
    endfunction

    always_comb begin
        bus.rd1  = rd(bus.ra1);
        bus.nrd1 = ~rd(bus.ra1);
        bus.rd2  = rd(bus.ra2);
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        else if (wr_en)
            mem_q[bus.wa] <= word_d;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: randomized and directed checks of two reg_bank configurations against array models.
module tb_reg_bank;
    logic clk = 1'b0;
    logic rst;
    logic we;
    logic [4:0] wa, ra1, ra2;
    logic [31:0] wd;
    logic [3:0] wbe;
    int checks = 0;
    int failures = 0;
    // Reference contents: A is 32 deep, entry 0 hardwired zero, no bypass; B is 20 deep, bypass on.
    logic [31:0] ma [32];
    logic [31:0] mb [20];

    always #5 clk = ~clk;

    reg_bank_if #(.WIDTH(32), .DEPTH(32)) ifa ();
    reg_bank_if #(.WIDTH(32), .DEPTH(20)) ifb ();

    assign ifa.we = we;   assign ifb.we = we;
    assign ifa.wa = wa;   assign ifb.wa = wa;
    assign ifa.wd = wd;   assign ifb.wd = wd;
    assign ifa.wbe = wbe; assign ifb.wbe = wbe;
    assign ifa.ra1 = ra1; assign ifb.ra1 = ra1;
    assign ifa.ra2 = ra2; assign ifb.ra2 = ra2;

    reg_bank #(.WIDTH(32), .DEPTH(32), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa));
    reg_bank #(.WIDTH(32), .DEPTH(20), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb));

    function automatic logic [31:0] rd1_of(int w);
        return w != 0 ? ifb.rd1 : ifa.rd1;
    endfunction
    function automatic logic [31:0] nrd1_of(int w);
        return w != 0 ? ifb.nrd1 : ifa.nrd1;
    endfunction
    function automatic logic [31:0] rd2_of(int w);
        return w != 0 ? ifb.rd2 : ifa.rd2;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Expected read value of DUT w at address ra, from the model and the current write-port inputs.
    function automatic logic [31:0] exp_rd(int w, logic [4:0] ra);
        if (w == 0) return ra == 0 ? 32'h0 : ma[ra];
        if (ra >= 20) return 32'h0;
        if (we && !rst && wa == ra) return merge(mb[ra], wd, wbe);
        return mb[ra];
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 32; i++) ma[i] = 32'h0;
        for (int i = 0; i < 20; i++) mb[i] = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) clear_models();
        else if (we) begin
            if (wa != 0) ma[wa] = merge(ma[wa], wd, wbe);
            if (wa < 20) mb[wa] = merge(mb[wa], wd, wbe);
        end
        #1;
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d, logic [3:0] be);
        we = 1'b1; wa = a; wd = d; wbe = be;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        ra1 = 5'd1; ra2 = 5'd2; #1;
        for (int w = 0; w < 2; w++) begin
            checks += 3;
            if (rd1_of(w) !== 32'h0) begin failures++; $display("FAIL reset_init dut%0d rd1 got %h want 0", w, rd1_of(w)); end
            if (nrd1_of(w) !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_init dut%0d nrd1 got %h want ffffffff", w, nrd1_of(w)); end
            if (rd2_of(w) !== 32'h0) begin failures++; $display("FAIL reset_init dut%0d rd2 got %h want 0", w, rd2_of(w)); end
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) wr(5'(i), 32'hDEAD_BEEF, 4'hF);
        ra1 = 5'd1; ra2 = 5'd3; #1;
        for (int w = 0; w < 2; w++) begin
            checks += 2;
            if (rd1_of(w) !== 32'hDEAD_BEEF) begin failures++; $display("FAIL reset_preload dut%0d rd1 got %h want deadbeef", w, rd1_of(w)); end
            if (rd2_of(w) !== 32'hDEAD_BEEF) begin failures++; $display("FAIL reset_preload dut%0d rd2 got %h want deadbeef", w, rd2_of(w)); end
        end
        // Mid-cycle assertion, with a forwardable write pending on port 1's address.
        #2;
        rst = 1'b1; clear_models();
        we = 1'b1; wa = 5'd1; wd = 32'h1234_5678; wbe = 4'hF;
        #1;
        for (int w = 0; w < 2; w++) begin
            checks += 3;
            if (rd1_of(w) !== 32'h0) begin failures++; $display("FAIL reset_async dut%0d rd1 got %h want 0", w, rd1_of(w)); end
            if (nrd1_of(w) !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_async dut%0d nrd1 got %h want ffffffff", w, nrd1_of(w)); end
            if (rd2_of(w) !== 32'h0) begin failures++; $display("FAIL reset_async dut%0d rd2 got %h want 0", w, rd2_of(w)); end
        end
        tick();
        rst = 1'b0; we = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ra1 = 5'(i); ra2 = 5'(i); #1;
            for (int w = 0; w < 2; w++) begin
                checks += 2;
                if (rd1_of(w) !== 32'h0) begin failures++; $display("FAIL reset_cleared dut%0d entry %0d rd1 got %h want 0", w, i, rd1_of(w)); end
                if (rd2_of(w) !== 32'h0) begin failures++; $display("FAIL reset_cleared dut%0d entry %0d rd2 got %h want 0", w, i, rd2_of(w)); end
            end
        end
    endtask

    task automatic test_byte_mask();
        wr(5'd5, 32'h1122_3344, 4'hF);
        wr(5'd5, 32'hAABB_CCDD, 4'b0101);
        ra1 = 5'd5; ra2 = 5'd5; #1;
        for (int w = 0; w < 2; w++) begin
            checks += 2;
            if (rd1_of(w) !== 32'h11BB_33DD) begin failures++; $display("FAIL byte_mask dut%0d rd1 got %h want 11bb33dd", w, rd1_of(w)); end
            if (rd2_of(w) !== 32'h11BB_33DD) begin failures++; $display("FAIL byte_mask dut%0d rd2 got %h want 11bb33dd", w, rd2_of(w)); end
        end
        wr(5'd5, 32'h0, 4'h0);
        #1;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (rd1_of(w) !== 32'h11BB_33DD) begin failures++; $display("FAIL byte_mask_wbe0 dut%0d rd1 got %h want 11bb33dd", w, rd1_of(w)); end
        end
    endtask

    task automatic test_zero();
        wr(5'd0, 32'h1234_5678, 4'hF);
        ra1 = 5'd0; ra2 = 5'd0; #1;
        for (int w = 0; w < 2; w++) begin
            logic [31:0] ex = w != 0 ? 32'h1234_5678 : 32'h0;
            checks += 3;
            if (rd1_of(w) !== ex) begin failures++; $display("FAIL zero_entry dut%0d rd1 got %h want %h", w, rd1_of(w), ex); end
            if (nrd1_of(w) !== ~ex) begin failures++; $display("FAIL zero_entry dut%0d nrd1 got %h want %h", w, nrd1_of(w), ~ex); end
            if (rd2_of(w) !== ex) begin failures++; $display("FAIL zero_entry dut%0d rd2 got %h want %h", w, rd2_of(w), ex); end
        end
    endtask

    task automatic test_bypass();
        wr(5'd7, 32'h0, 4'hF);
        we = 1'b1; wa = 5'd7; wd = 32'hCAFE_F00D; wbe = 4'hF; ra1 = 5'd7; ra2 = 5'd7; #1;
        for (int w = 0; w < 2; w++) begin
            logic [31:0] ex = w != 0 ? 32'hCAFE_F00D : 32'h0;
            checks += 3;
            if (rd1_of(w) !== ex) begin failures++; $display("FAIL bypass_pre dut%0d rd1 got %h want %h", w, rd1_of(w), ex); end
            if (nrd1_of(w) !== ~ex) begin failures++; $display("FAIL bypass_pre dut%0d nrd1 got %h want %h", w, nrd1_of(w), ~ex); end
            if (rd2_of(w) !== ex) begin failures++; $display("FAIL bypass_pre dut%0d rd2 got %h want %h", w, rd2_of(w), ex); end
        end
        tick();
        we = 1'b0; #1;
        for (int w = 0; w < 2; w++) begin
            checks += 2;
            if (rd1_of(w) !== 32'hCAFE_F00D) begin failures++; $display("FAIL bypass_post dut%0d rd1 got %h want cafef00d", w, rd1_of(w)); end
            if (rd2_of(w) !== 32'hCAFE_F00D) begin failures++; $display("FAIL bypass_post dut%0d rd2 got %h want cafef00d", w, rd2_of(w)); end
        end
        // Partial-mask forward returns the merged word.
        we = 1'b1; wd = 32'h0; wbe = 4'b0011; #1;
        for (int w = 0; w < 2; w++) begin
            logic [31:0] ex = w != 0 ? 32'hCAFE_0000 : 32'hCAFE_F00D;
            checks++;
            if (rd1_of(w) !== ex) begin failures++; $display("FAIL bypass_merge dut%0d rd1 got %h want %h", w, rd1_of(w), ex); end
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_range();
        wr(5'd25, 32'hFFFF_FFFF, 4'hF);
        ra1 = 5'd25; ra2 = 5'd19; #1;
        checks += 3;
        if (ifb.rd1 !== 32'h0) begin failures++; $display("FAIL range dut1 rd1 got %h want 0", ifb.rd1); end
        if (ifb.nrd1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL range dut1 nrd1 got %h want ffffffff", ifb.nrd1); end
        if (ifa.rd1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL range dut0 rd1 got %h want ffffffff", ifa.rd1); end
        for (int i = 0; i < 20; i++) begin
            ra2 = 5'(i); #1;
            checks++;
            if (ifb.rd2 !== mb[i]) begin failures++; $display("FAIL range_intact dut1 entry %0d got %h want %h", i, ifb.rd2, mb[i]); end
        end
        we = 1'b1; wa = 5'd25; wd = 32'h5A5A_5A5A; wbe = 4'hF; #1;
        checks++;
        if (ifb.rd1 !== 32'h0) begin failures++; $display("FAIL range_bypass dut1 rd1 got %h want 0", ifb.rd1); end
        tick();
        we = 1'b0;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] d = $urandom();
            d[31:24] = 8'(i);
            wr(5'(i), d, 4'hF);
        end
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i); #1;
            for (int w = 0; w < 2; w++) begin
                logic [31:0] e1 = exp_rd(w, ra1);
                logic [31:0] e2 = exp_rd(w, ra2);
                checks += 3;
                if (rd1_of(w) !== e1) begin failures++; $display("FAIL sweep dut%0d ra1=%0d got %h want %h", w, ra1, rd1_of(w), e1); end
                if (nrd1_of(w) !== ~e1) begin failures++; $display("FAIL sweep dut%0d nrd1 ra1=%0d got %h want %h", w, ra1, nrd1_of(w), ~e1); end
                if (rd2_of(w) !== e2) begin failures++; $display("FAIL sweep dut%0d ra2=%0d got %h want %h", w, ra2, rd2_of(w), e2); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; wa = 5'd9; wd = 32'h1111_1111; wbe = 4'hF;
        tick();
        wd = 32'h2222_2222; wbe = 4'b1100;
        tick();
        wd = 32'h3333_3333; wbe = 4'b0001;
        tick();
        we = 1'b0; ra1 = 5'd9; ra2 = 5'd9; #1;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (rd1_of(w) !== 32'h2222_1133) begin failures++; $display("FAIL back_to_back dut%0d rd1 got %h want 22221133", w, rd1_of(w)); end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom());
            wd = $urandom();
            wbe = 4'($urandom());
            ra1 = $urandom_range(0, 2) == 0 ? wa : 5'($urandom());
            ra2 = $urandom_range(0, 2) == 0 ? wa : 5'($urandom());
            #1;
            for (int w = 0; w < 2; w++) begin
                logic [31:0] e1 = exp_rd(w, ra1);
                logic [31:0] e2 = exp_rd(w, ra2);
                checks += 3;
                if (rd1_of(w) !== e1) begin failures++; $display("FAIL random dut%0d ra1=%0d got %h want %h", w, ra1, rd1_of(w), e1); end
                if (nrd1_of(w) !== ~e1) begin failures++; $display("FAIL random dut%0d nrd1 ra1=%0d got %h want %h", w, ra1, nrd1_of(w), ~e1); end
                if (rd2_of(w) !== e2) begin failures++; $display("FAIL random dut%0d ra2=%0d got %h want %h", w, ra2, rd2_of(w), e2); end
            end
            tick();
        end
        we = 1'b0;
    endtask

    initial begin
        we = 1'b0; wa = '0; wd = '0; wbe = '0; ra1 = '0; ra2 = '0;
        rst = 1'b1;
        clear_models();
        repeat (2) tick();
        test_reset();
        test_byte_mask();
        test_zero();
        test_bypass();
        test_range();
        test_sweep();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
